// File: rtl/pin_entry_if.sv
// pin_entry_if: keypad strobes, lock comparator result and controller status.
interface pin_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_clr;
  logic        key_enter;
  logic        lock_unlock;
  logic [15:0] pin_out;
  logic        pin_check;
  logic        unlocked;
  logic        lockout;
  logic [2:0]  digit_cnt;
  logic [2:0]  fail_cnt;
  modport master (
    output key_valid, key_code, key_clr, key_enter, lock_unlock,
    input  pin_out, pin_check, unlocked, lockout, digit_cnt, fail_cnt
  );
  modport slave (
    input  key_valid, key_code, key_clr, key_enter, lock_unlock,
    output pin_out, pin_check, unlocked, lockout, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/pin_entry_controller.sv
// pin_entry_controller: collects a 4-digit hex PIN, checks it for one cycle, times open/lockout.
module pin_entry_controller #(
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input logic        clk,
  input logic        rst_n,
  pin_entry_if.slave bus
);
  localparam int TMAX = OPEN_CYCLES > LOCKOUT_CYCLES ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_t;
  state_t         state, state_d;
  logic [15:0]    pin, pin_d;
  logic [2:0]     dcnt, dcnt_d, fcnt, fcnt_d;
  logic [TW-1:0]  tmr, tmr_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ENTRY;
      pin   <= '0;
      dcnt  <= '0;
      fcnt  <= '0;
      tmr   <= '0;
    end else begin
      state <= state_d;
      pin   <= pin_d;
      dcnt  <= dcnt_d;
      fcnt  <= fcnt_d;
      tmr   <= tmr_d;
    end
  end
  always_comb begin
    state_d = state;
    pin_d   = pin;
    dcnt_d  = dcnt;
    fcnt_d  = fcnt;
    tmr_d   = tmr;
    unique case (state)
      ENTRY: begin
        if (bus.key_clr) begin
          pin_d  = '0;
          dcnt_d = '0;
        end else if (bus.key_enter) begin
          if (dcnt == 3'd4) state_d = CHECK;
        end else if (bus.key_valid && dcnt < 3'd4) begin
          pin_d  = {pin[11:0], bus.key_code};
          dcnt_d = dcnt + 3'd1;
        end
      end
      CHECK: begin
        pin_d  = '0;
        dcnt_d = '0;
        if (bus.lock_unlock) begin
          fcnt_d  = '0;
          tmr_d   = TW'(OPEN_CYCLES);
          state_d = OPEN;
        end else if (fcnt + 3'd1 == 3'(MAX_TRIES)) begin
          fcnt_d  = 3'(MAX_TRIES);
          tmr_d   = TW'(LOCKOUT_CYCLES);
          state_d = LOCKOUT;
        end else begin
          fcnt_d  = fcnt + 3'd1;
          state_d = ENTRY;
        end
      end
      OPEN: begin
        tmr_d   = tmr - TW'(1);
        state_d = (bus.key_clr || tmr == TW'(1)) ? ENTRY : OPEN;
      end
      LOCKOUT: begin
        tmr_d = tmr - TW'(1);
        if (tmr == TW'(1)) begin
          fcnt_d  = '0;
          state_d = ENTRY;
        end
      end
      default: state_d = ENTRY;
    endcase
  end
  assign bus.pin_out   = pin;
  assign bus.digit_cnt = dcnt;
  assign bus.fail_cnt  = fcnt;
  assign bus.pin_check = state == CHECK;
  assign bus.unlocked  = state == OPEN;
  assign bus.lockout   = state == LOCKOUT;
endmodule

// File: tb/tb_pin_entry_controller.sv
// tb_pin_entry_controller: directed scenarios against a lock that opens only for 16'hABC7.
module tb_pin_entry_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  pin_entry_if ifc ();
  pin_entry_controller #(.MAX_TRIES(3), .OPEN_CYCLES(8), .LOCKOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );
  always #5 clk = ~clk;
  assign ifc.lock_unlock = (ifc.pin_out == 16'hABC7);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [3:0] c);
    ifc.key_valid = 1'b1;
    ifc.key_code  = c;
    tick();
    ifc.key_valid = 1'b0;
  endtask
  task automatic enter_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) press(p[i*4 +: 4]);
  endtask
  task automatic submit();
    ifc.key_enter = 1'b1;
    tick();
    ifc.key_enter = 1'b0;
  endtask
  task automatic clear();
    ifc.key_clr = 1'b1;
    tick();
    ifc.key_clr = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if ({ifc.pin_out, ifc.pin_check, ifc.unlocked, ifc.lockout, ifc.digit_cnt, ifc.fail_cnt} !== 25'd0) begin errors++; $display("FAIL reset_state got=%h exp=0", {ifc.pin_out, ifc.pin_check, ifc.unlocked, ifc.lockout, ifc.digit_cnt, ifc.fail_cnt}); end
  endtask
  task automatic test_unlock();
    enter_pin(16'hABC7);
    checks++; if (ifc.pin_out !== 16'hABC7) begin errors++; $display("FAIL t1_pin got=%h exp=abc7", ifc.pin_out); end
    checks++; if (ifc.digit_cnt !== 3'd4) begin errors++; $display("FAIL t1_dcnt got=%0d exp=4", ifc.digit_cnt); end
    submit();
    checks++; if (ifc.pin_check !== 1'b1) begin errors++; $display("FAIL t1_check got=%b exp=1", ifc.pin_check); end
    tick();
    checks++; if (ifc.pin_check !== 1'b0) begin errors++; $display("FAIL t1_check_drop got=%b exp=0", ifc.pin_check); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (ifc.unlocked !== 1'b1) begin errors++; $display("FAIL t1_open_c%0d got=%b exp=1", i, ifc.unlocked); end
      tick();
    end
    checks++; if (ifc.unlocked !== 1'b0) begin errors++; $display("FAIL t1_open_end got=%b exp=0", ifc.unlocked); end
    checks++; if (ifc.fail_cnt !== 3'd0) begin errors++; $display("FAIL t1_fcnt got=%0d exp=0", ifc.fail_cnt); end
  endtask
  task automatic fail_attempt(input logic [15:0] p, input logic [2:0] exp_f);
    enter_pin(p);
    submit();
    checks++; if (ifc.pin_check !== 1'b1) begin errors++; $display("FAIL fail_check_%h got=%b exp=1", p, ifc.pin_check); end
    tick();
    checks++; if (ifc.fail_cnt !== exp_f) begin errors++; $display("FAIL fail_cnt_%h got=%0d exp=%0d", p, ifc.fail_cnt, exp_f); end
    checks++; if (ifc.digit_cnt !== 3'd0) begin errors++; $display("FAIL fail_dcnt_%h got=%0d exp=0", p, ifc.digit_cnt); end
  endtask
  task automatic test_lockout();
    logic [3:0] keys [4] = '{4'hA, 4'hB, 4'hC, 4'h7};
    int n = 0;
    fail_attempt(16'h123D, 3'd1);
    checks++; if (ifc.lockout !== 1'b0) begin errors++; $display("FAIL t2_no_lock1 got=%b exp=0", ifc.lockout); end
    fail_attempt(16'h5623, 3'd2);
    fail_attempt(16'hA1B2, 3'd3);
    while (ifc.lockout === 1'b1 && n < 40) begin
      ifc.key_valid = n < 4;
      ifc.key_code  = keys[n < 4 ? n : 0];
      ifc.key_enter = n == 4;
      ifc.key_clr   = n == 5;
      tick();
      ifc.key_valid = 1'b0;
      ifc.key_enter = 1'b0;
      ifc.key_clr   = 1'b0;
      n++;
      checks++; if (ifc.digit_cnt !== 3'd0 || ifc.unlocked !== 1'b0 || ifc.pin_check !== 1'b0) begin errors++; $display("FAIL t2_keys_ignored n=%0d dcnt=%0d open=%b chk=%b exp=0,0,0", n, ifc.digit_cnt, ifc.unlocked, ifc.pin_check); end
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL t2_lock_len got=%0d exp=16", n); end
    checks++; if (ifc.fail_cnt !== 3'd0) begin errors++; $display("FAIL t2_fcnt_after got=%0d exp=0", ifc.fail_cnt); end
  endtask
  task automatic test_clear();
    press(4'hA);
    press(4'hB);
    clear();
    press(4'hC);
    press(4'h7);
    checks++; if (ifc.pin_out !== 16'h00C7) begin errors++; $display("FAIL t3_pin got=%h exp=00c7", ifc.pin_out); end
    checks++; if (ifc.digit_cnt !== 3'd2) begin errors++; $display("FAIL t3_dcnt got=%0d exp=2", ifc.digit_cnt); end
    submit();
    checks++; if (ifc.pin_check !== 1'b0) begin errors++; $display("FAIL t3_short_enter got=%b exp=0", ifc.pin_check); end
    checks++; if (ifc.fail_cnt !== 3'd0) begin errors++; $display("FAIL t3_fcnt got=%0d exp=0", ifc.fail_cnt); end
    clear();
  endtask
  task automatic test_overflow_early_relock();
    enter_pin(16'hABC7);
    press(4'h9);
    checks++; if (ifc.pin_out !== 16'hABC7) begin errors++; $display("FAIL t4_pin got=%h exp=abc7", ifc.pin_out); end
    checks++; if (ifc.digit_cnt !== 3'd4) begin errors++; $display("FAIL t4_dcnt got=%0d exp=4", ifc.digit_cnt); end
    submit();
    tick();
    tick();
    tick();
    checks++; if (ifc.unlocked !== 1'b1) begin errors++; $display("FAIL t4_open3 got=%b exp=1", ifc.unlocked); end
    clear();
    checks++; if (ifc.unlocked !== 1'b0) begin errors++; $display("FAIL t4_early_relock got=%b exp=0", ifc.unlocked); end
  endtask
  task automatic test_same_cycle();
    enter_pin(16'hABC7);
    ifc.key_valid = 1'b1;
    ifc.key_code  = 4'h9;
    ifc.key_enter = 1'b1;
    tick();
    ifc.key_valid = 1'b0;
    ifc.key_enter = 1'b0;
    checks++; if (ifc.pin_check !== 1'b1) begin errors++; $display("FAIL t5_enter_wins got=%b exp=1", ifc.pin_check); end
    checks++; if (ifc.pin_out !== 16'hABC7) begin errors++; $display("FAIL t5_no_shift got=%h exp=abc7", ifc.pin_out); end
    tick();
    checks++; if (ifc.unlocked !== 1'b1) begin errors++; $display("FAIL t5_open got=%b exp=1", ifc.unlocked); end
    clear();
    enter_pin(16'h1234);
    ifc.key_clr   = 1'b1;
    ifc.key_enter = 1'b1;
    tick();
    ifc.key_clr   = 1'b0;
    ifc.key_enter = 1'b0;
    checks++; if (ifc.pin_check !== 1'b0) begin errors++; $display("FAIL t5_clr_wins got=%b exp=0", ifc.pin_check); end
    checks++; if ({ifc.pin_out, ifc.digit_cnt} !== 19'd0) begin errors++; $display("FAIL t5_clr_state got=%h exp=0", {ifc.pin_out, ifc.digit_cnt}); end
  endtask
  task automatic test_reset_midway();
    fail_attempt(16'h0001, 3'd1);
    fail_attempt(16'h0002, 3'd2);
    fail_attempt(16'h0003, 3'd3);
    for (int i = 0; i < 5; i++) tick();
    checks++; if (ifc.lockout !== 1'b1) begin errors++; $display("FAIL t6_in_lock got=%b exp=1", ifc.lockout); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({ifc.pin_out, ifc.pin_check, ifc.unlocked, ifc.lockout, ifc.digit_cnt, ifc.fail_cnt} !== 25'd0) begin errors++; $display("FAIL t6_rst_lock got=%h exp=0", {ifc.pin_out, ifc.pin_check, ifc.unlocked, ifc.lockout, ifc.digit_cnt, ifc.fail_cnt}); end
    enter_pin(16'hABC7);
    submit();
    tick();
    tick();
    tick();
    checks++; if (ifc.unlocked !== 1'b1) begin errors++; $display("FAIL t6_open_after_lock got=%b exp=1", ifc.unlocked); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({ifc.pin_out, ifc.pin_check, ifc.unlocked, ifc.lockout, ifc.digit_cnt, ifc.fail_cnt} !== 25'd0) begin errors++; $display("FAIL t6_rst_open got=%h exp=0", {ifc.pin_out, ifc.pin_check, ifc.unlocked, ifc.lockout, ifc.digit_cnt, ifc.fail_cnt}); end
    enter_pin(16'hABC7);
    submit();
    tick();
    checks++; if (ifc.unlocked !== 1'b1) begin errors++; $display("FAIL t6_final_unlock got=%b exp=1", ifc.unlocked); end
  endtask
  initial begin
    ifc.key_valid = 1'b0;
    ifc.key_code  = 4'h0;
    ifc.key_clr   = 1'b0;
    ifc.key_enter = 1'b0;
    test_reset();
    test_unlock();
    test_lockout();
    test_clear();
    test_overflow_early_relock();
    test_same_cycle();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
